// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave with every pin resampled into the clk domain.
// Edges on the synchronized ssn/sclk drive a two-state IDLE/SHIFT engine with 1-entry TX and RX buffers.
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ssn,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ssn_dly_q, ssn_dly_d;
  logic                   sclk_dly_q, sclk_dly_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic                   frame_done_q, frame_done_d;
  logic [WIDTH-1:0]       txbuf_q, txbuf_d;
  logic                   txbuf_full_q, txbuf_full_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   busy_q, busy_d;

  logic             ssn_s, sclk_s, mosi_s;
  logic             ssn_fall, ssn_rise, sclk_rise, sclk_fall;
  logic             load;
  logic [WIDTH-1:0] rx_next;

  always_comb begin
    ssn_sync_d[0]  = ssn;
    sclk_sync_d[0] = sclk;
    mosi_sync_d[0] = mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ssn_sync_d[i]  = ssn_sync_q[i-1];
      sclk_sync_d[i] = sclk_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
  end

  assign ssn_s      = ssn_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign ssn_dly_d  = ssn_s;
  assign sclk_dly_d = sclk_s;

  assign ssn_fall  = ssn_dly_q & ~ssn_s;
  assign ssn_rise  = ~ssn_dly_q & ssn_s;
  assign sclk_rise = ~sclk_dly_q & sclk_s;
  assign sclk_fall = sclk_dly_q & ~sclk_s;

  assign rx_next = (rx_shift_q << 1) | WIDTH'(mosi_s);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    frame_done_d = frame_done_q;
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;
    load         = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ssn_fall) begin
          state_d      = SHIFT;
          bit_cnt_d    = '0;
          frame_done_d = 1'b0;
          load         = 1'b1;
        end
      end
      SHIFT: begin
        if (ssn_rise) begin
          state_d      = IDLE;
          bit_cnt_d    = '0;
          tx_shift_d   = '0;
          rx_shift_d   = '0;
          frame_done_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            frame_done_d = 1'b1;
            // An unconsumed byte wins; the new one is dropped and flagged.
            if (rx_valid_q && !rx_ready) begin
              overrun_d = 1'b1;
            end else begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (frame_done_q) begin
            load         = 1'b1;
            frame_done_d = 1'b0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load sees the buffer as it was before this cycle; a same-cycle write only refills it.
    if (load) begin
      tx_shift_d   = txbuf_full_q ? txbuf_q : '0;
      txbuf_d      = '0;
      txbuf_full_d = 1'b0;
    end
    if (tx_valid && !txbuf_full_q) begin
      txbuf_d      = tx_data;
      txbuf_full_d = 1'b1;
    end

    miso_d    = (state_d == SHIFT) ? tx_shift_d[WIDTH-1] : 1'b0;
    miso_oe_d = (state_d == SHIFT);
    busy_d    = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ssn_sync_q   <= '1;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ssn_dly_q    <= 1'b1;
      sclk_dly_q   <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      frame_done_q <= 1'b0;
      txbuf_q      <= '0;
      txbuf_full_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ssn_sync_q   <= ssn_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ssn_dly_q    <= ssn_dly_d;
      sclk_dly_q   <= sclk_dly_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      frame_done_q <= frame_done_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      busy_q       <= busy_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign busy     = busy_q;
  assign tx_ready = ~txbuf_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a behavioural mode-0 master exchanges frames
// and every result is compared against hand-computed values.
module tb_spi_slave_sync;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       ssn, sclk, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, overrun;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [7:0] mi, mi2;

  spi_slave_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ssn(ssn), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: set mosi while sclk low, sample miso just before raising sclk.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(HALF);
      got[7-i] = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ssn = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %b exp 0", miso); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe got %b exp 0", miso_oe); else pass_cnt++;
    chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", tx_ready); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else pass_cnt++;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_preload();
    tx_write(8'h92);
    chk_cnt++; if (tx_ready !== 1'b0) $display("FAIL preload_full got tx_ready=%b exp 0", tx_ready); else pass_cnt++;
    ssn = 1'b0;
    wait_clk(8);
    chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL preload_loaded got tx_ready=%b exp 1", tx_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL preload_busy got %b exp 1", busy); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b1) $display("FAIL preload_oe got %b exp 1", miso_oe); else pass_cnt++;
    spi_bits(8'h53, 8, mi);
    chk_cnt++; if (mi !== 8'h92) $display("FAIL preload_miso got %h exp 92", mi); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h53) $display("FAIL preload_rx_data got %h exp 53", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL preload_rx_valid got %b exp 1", rx_valid); else pass_cnt++;
    consume();
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL preload_consume got rx_valid=%b exp 0", rx_valid); else pass_cnt++;
    ssn = 1'b1;
    wait_clk(8);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL preload_idle got busy=%b exp 0", busy); else pass_cnt++;
    $display("preload: tx 92 / rx 53 -> master got %h, rx_data %h", mi, rx_data);
  endtask

  task automatic test_empty_tx();
    ssn = 1'b0;
    wait_clk(8);
    spi_bits(8'hA5, 8, mi);
    chk_cnt++; if (mi !== 8'h00) $display("FAIL empty_miso got %h exp 00", mi); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'hA5) $display("FAIL empty_rx_data got %h exp a5", rx_data); else pass_cnt++;
    consume();
    ssn = 1'b1;
    wait_clk(8);
    $display("empty_tx: rx a5 -> master got %h, rx_data %h", mi, rx_data);
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b1;
    tx_write(8'h3C);
    ssn = 1'b0;
    wait_clk(8);
    tx_write(8'hC3);
    spi_bits(8'h11, 8, mi);
    chk_cnt++; if (mi !== 8'h3C) $display("FAIL b2b_miso1 got %h exp 3c", mi); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h11) $display("FAIL b2b_rx1 got %h exp 11", rx_data); else pass_cnt++;
    spi_bits(8'h22, 8, mi2);
    chk_cnt++; if (mi2 !== 8'hC3) $display("FAIL b2b_miso2 got %h exp c3", mi2); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h22) $display("FAIL b2b_rx2 got %h exp 22", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL b2b_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b exp 0", overrun); else pass_cnt++;
    rx_ready = 1'b0;
    ssn = 1'b1;
    wait_clk(8);
    $display("back_to_back: master got %h %h, last rx %h", mi, mi2, rx_data);
  endtask

  task automatic test_overrun();
    ssn = 1'b0;
    wait_clk(8);
    spi_bits(8'h44, 8, mi);
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_first got overrun=%b exp 0", overrun); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got %b exp 1", rx_valid); else pass_cnt++;
    spi_bits(8'h55, 8, mi);
    chk_cnt++; if (rx_data !== 8'h44) $display("FAIL ovr_rx_data got %h exp 44", rx_data); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b exp 1", overrun); else pass_cnt++;
    consume();
    ssn = 1'b1;
    wait_clk(8);
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun); else pass_cnt++;
    $display("overrun: rx_data %h overrun %b", rx_data, overrun);
  endtask

  task automatic test_abort();
    ssn = 1'b0;
    wait_clk(8);
    spi_bits(8'hF0, 5, mi);
    ssn = 1'b1;
    wait_clk(3);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL abort_oe got %b exp 0", miso_oe); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL abort_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
    wait_clk(8);
    ssn = 1'b0;
    wait_clk(8);
    spi_bits(8'h7E, 8, mi);
    chk_cnt++; if (rx_data !== 8'h7E) $display("FAIL abort_next_rx got %h exp 7e", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL abort_next_valid got %b exp 1", rx_valid); else pass_cnt++;
    consume();
    ssn = 1'b1;
    wait_clk(8);
    $display("abort: partial frame dropped, next rx %h", rx_data);
  endtask

  task automatic test_mid_reset();
    ssn = 1'b0;
    wait_clk(8);
    tx_write(8'h5A);
    spi_bits(8'hFF, 3, mi);
    rst = 1'b1;
    wait_clk(1);
    chk_cnt++; if (miso !== 1'b0) $display("FAIL mrst_miso got %b exp 0", miso); else pass_cnt++;
    chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL mrst_oe got %b exp 0", miso_oe); else pass_cnt++;
    chk_cnt++; if (tx_ready !== 1'b1) $display("FAIL mrst_tx_ready got %b exp 1", tx_ready); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL mrst_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL mrst_rx_data got %h exp 00", rx_data); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mrst_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL mrst_overrun got %b exp 0", overrun); else pass_cnt++;
    rst = 1'b0;
    ssn = 1'b1;
    wait_clk(8);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mrst_no_edge got busy=%b exp 0", busy); else pass_cnt++;
    ssn = 1'b0;
    wait_clk(8);
    spi_bits(8'h81, 8, mi);
    chk_cnt++; if (rx_data !== 8'h81) $display("FAIL mrst_next_rx got %h exp 81", rx_data); else pass_cnt++;
    chk_cnt++; if (rx_valid !== 1'b1) $display("FAIL mrst_next_valid got %b exp 1", rx_valid); else pass_cnt++;
    chk_cnt++; if (mi !== 8'h00) $display("FAIL mrst_next_miso got %h exp 00", mi); else pass_cnt++;
    consume();
    ssn = 1'b1;
    wait_clk(8);
    $display("mid_reset: next rx %h, master got %h", rx_data, mi);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_empty_tx();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
